// File: rtl/gemm_pkg.sv
// ---------------------------------------------------------------------------
// gemm_pkg
// Items shared by the GEMM accelerator blocks: the C-writeback state
// encoding, the bus word size, the default tile size and the helper that
// locates one accumulator inside a flattened tile vector.
// ---------------------------------------------------------------------------
package gemm_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } wb_state_e;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned PE_ROWS_DEF = 8;
    localparam int unsigned PE_COLS_DEF = 8;
    localparam int unsigned TILE_WORDS  = PE_ROWS_DEF * PE_COLS_DEF;

    // Bit offset of element (row, col) in a row-major flattened tile.
    function automatic int unsigned elem_lsb(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols,
                                             input int unsigned width);
        return (row * cols + col) * width;
    endfunction

endpackage

// File: rtl/gemm_c_writeback_if.sv
// ---------------------------------------------------------------------------
// gemm_c_writeback_if
// Bundles the tile-capture port, the word write port and the status/error
// signals of gemm_c_writeback.
//   slave  : the writeback block (captures tiles, issues writes)
//   master : the surrounding logic (offers tiles, accepts writes)
// ---------------------------------------------------------------------------
interface gemm_c_writeback_if #(
    parameter int unsigned PE_ROWS    = 8,
    parameter int unsigned PE_COLS    = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // tile capture
    logic [ADDR_WIDTH-1:0]                  c_addr;
    logic                                   c_valid;
    logic [ACC_WIDTH*PE_ROWS*PE_COLS-1:0]   c_data;
    logic [ADDR_WIDTH-1:0]                  row_stride;
    logic                                   tile_ready;
    // word write port
    logic [ADDR_WIDTH-1:0]                  wr_addr;
    logic [31:0]                            wr_data;
    logic [3:0]                             wr_strb;
    logic                                   wr_valid;
    logic                                   wr_ready;
    // status
    logic                                   tile_done;
    logic                                   overflow;
    logic                                   err_clr;
    logic [31:0]                            words_written;

    modport slave (
        input  c_addr, c_valid, c_data, row_stride, wr_ready, err_clr,
        output tile_ready, wr_addr, wr_data, wr_strb, wr_valid,
               tile_done, overflow, words_written
    );

    modport master (
        output c_addr, c_valid, c_data, row_stride, wr_ready, err_clr,
        input  tile_ready, wr_addr, wr_data, wr_strb, wr_valid,
               tile_done, overflow, words_written
    );

endinterface

// File: rtl/gemm_wb_addr_gen.sv
// ---------------------------------------------------------------------------
// gemm_wb_addr_gen
// Row/column counters and the write address for the tile drain.
// The address is built incrementally (row_base += stride at each row end,
// addr = row_base + col*WORD_BYTES) so no multiplier is needed; all sums
// wrap modulo 2^ADDR_WIDTH.
//   i_load    : start a new tile at i_base with row pitch i_stride
//   i_advance : step to the next element (row-major)
//   o_addr    : byte address of the current element
//   o_row/o_col : current element coordinates
//   o_last    : current element is the final one of the tile
// ---------------------------------------------------------------------------
module gemm_wb_addr_gen
    import gemm_pkg::*;
#(
    parameter int unsigned PE_ROWS    = 8,
    parameter int unsigned PE_COLS    = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    localparam int unsigned RW = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1,
    localparam int unsigned CW = (PE_COLS > 1) ? $clog2(PE_COLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [RW-1:0]         o_row,
    output logic [CW-1:0]         o_col,
    output logic                  o_last
);

    localparam int unsigned BYTE_SHIFT = $clog2(WORD_BYTES);

    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic                  w_col_end;

    assign w_col_end = (r_col == CW'(PE_COLS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_base <= '0;
            r_stride   <= '0;
            r_row      <= '0;
            r_col      <= '0;
        end else if (i_load) begin
            r_row_base <= i_base;
            r_stride   <= i_stride;
            r_row      <= '0;
            r_col      <= '0;
        end else if (i_advance) begin
            if (w_col_end) begin
                r_col      <= '0;
                r_row      <= r_row + RW'(1);
                r_row_base <= r_row_base + r_stride;
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_addr = r_row_base + (ADDR_WIDTH'(r_col) << BYTE_SHIFT);
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == RW'(PE_ROWS - 1)) && w_col_end;

endmodule

// File: rtl/gemm_c_writeback.sv
// ---------------------------------------------------------------------------
// gemm_c_writeback
// Captures one PE_ROWS x PE_COLS accumulator tile in a single cycle and
// drains it as 32-bit word writes, row-major, at base + r*stride + c*4.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gemm_c_writeback_if.slave
//                c_addr/c_valid/c_data/row_stride/tile_ready : tile capture
//                wr_addr/wr_data/wr_strb/wr_valid/wr_ready    : write port
//                tile_done  : pulse after the last word is accepted
//                overflow   : sticky, tile offered while busy (err_clr clears)
//                words_written : accepted-word counter, wraps
// ACC_WIDTH must be 32: one accumulator per bus word.
// ---------------------------------------------------------------------------
module gemm_c_writeback
    import gemm_pkg::*;
#(
    parameter int unsigned PE_ROWS    = 8,
    parameter int unsigned PE_COLS    = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    gemm_c_writeback_if.slave bus
);

    localparam int unsigned TILE_BITS = ACC_WIDTH * PE_ROWS * PE_COLS;
    localparam int unsigned RW = (PE_ROWS > 1) ? $clog2(PE_ROWS) : 1;
    localparam int unsigned CW = (PE_COLS > 1) ? $clog2(PE_COLS) : 1;

    wb_state_e             r_state;
    logic                  r_tile_ready;
    logic                  r_wr_valid;
    logic                  r_tile_done;
    logic                  r_overflow;
    logic [31:0]           r_words_written;
    logic [TILE_BITS-1:0]  r_tile;

    logic                  w_capture;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col;

    assign w_capture = (r_state == ST_IDLE) && bus.c_valid;
    assign w_accept  = r_wr_valid && bus.wr_ready;
    // Counters freeze on the final word so they never run past the tile.
    assign w_advance = w_accept && !w_last;

    gemm_wb_addr_gen #(
        .PE_ROWS    (PE_ROWS),
        .PE_COLS    (PE_COLS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_capture),
        .i_base    (bus.c_addr),
        .i_stride  (bus.row_stride),
        .i_advance (w_advance),
        .o_addr    (w_addr),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_tile_ready <= 1'b1;
            r_wr_valid   <= 1'b0;
            r_tile_done  <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.c_valid) begin
                        r_state      <= ST_DRAIN;
                        r_tile_ready <= 1'b0;
                        r_wr_valid   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (w_accept && w_last) begin
                        r_state      <= ST_IDLE;
                        r_tile_ready <= 1'b1;
                        r_wr_valid   <= 1'b0;
                        r_tile_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_tile_ready <= 1'b1;
                    r_wr_valid   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile <= '0;
        end else if (w_capture) begin
            r_tile <= bus.c_data;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (bus.c_valid && !r_tile_ready) begin
            r_overflow <= 1'b1;
        end else if (bus.err_clr) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words_written <= '0;
        end else if (w_accept) begin
            r_words_written <= r_words_written + 32'd1;
        end
    end

    assign bus.tile_ready    = r_tile_ready;
    assign bus.wr_valid      = r_wr_valid;
    assign bus.wr_addr       = w_addr;
    assign bus.wr_data       = r_tile[elem_lsb(32'(w_row), 32'(w_col), PE_COLS, ACC_WIDTH) +: 32];
    assign bus.wr_strb       = r_wr_valid ? 4'hF : 4'h0;
    assign bus.tile_done     = r_tile_done;
    assign bus.overflow      = r_overflow;
    assign bus.words_written = r_words_written;

endmodule

// File: tb/tb_gemm_c_writeback.sv
// ---------------------------------------------------------------------------
// tb_gemm_c_writeback
// Directed bench for gemm_c_writeback (8x8 tile, 32-bit addresses).
// ---------------------------------------------------------------------------
module tb_gemm_c_writeback;

    logic clk;
    logic rst_n;

    gemm_c_writeback_if #(
        .PE_ROWS    (8),
        .PE_COLS    (8),
        .ACC_WIDTH  (32),
        .ADDR_WIDTH (32)
    ) bus ();

    gemm_c_writeback #(
        .PE_ROWS    (8),
        .PE_COLS    (8),
        .ACC_WIDTH  (32),
        .ADDR_WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] tag;          // element (r,c) = tag + r*16 + c
        bit          stall;        // wr_ready toggles 0/1 per valid cycle
        int          inject_at;    // extra c_valid once this many words accepted
        int          abort_at;     // reset once this many words accepted
        bit          chain_next;   // next tile offered in the tile_done cycle
        logic [31:0] exp_first_addr;
        logic [31:0] exp_last_addr;
        logic [31:0] exp_mid_addr; // address of word 8 (row 1, col 0)
        int          exp_valid_cycles;
        logic [31:0] exp_ww;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2047:0] make_tile(input logic [31:0] tag);
        logic [2047:0] t;
        t = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                t[(r*8+c)*32 +: 32] = tag + 32'(r*16 + c);
        return t;
    endfunction

    task automatic check_reset_values();
        check("rst_tile_ready",    32'(bus.tile_ready), 32'd1);
        check("rst_wr_valid",      32'(bus.wr_valid),   32'd0);
        check("rst_wr_addr",       bus.wr_addr,         32'd0);
        check("rst_wr_data",       bus.wr_data,         32'd0);
        check("rst_wr_strb",       32'(bus.wr_strb),    32'd0);
        check("rst_tile_done",     32'(bus.tile_done),  32'd0);
        check("rst_overflow",      32'(bus.overflow),   32'd0);
        check("rst_words_written", bus.words_written,   32'd0);
    endtask

    // Offer a tile at the current negedge and follow its drain. Returns at
    // the negedge where tile_done is seen (or right after an abort reset).
    task automatic run_tile(input vec_t v, output int n_valid, output int n_acc);
        int          widx, cyc, vcyc, r, c;
        bit          done, prev_stall;
        logic [31:0] p_addr, p_data, exp_a, exp_d;
        widx = 0; cyc = 0; vcyc = 0; done = 0; prev_stall = 0;
        p_addr = '0; p_data = '0;
        check("ready_at_offer", 32'(bus.tile_ready), 32'd1);
        bus.c_addr     = v.base;
        bus.row_stride = v.stride;
        bus.c_data     = make_tile(v.tag);
        bus.c_valid    = 1'b1;
        bus.wr_ready   = 1'b0;
        @(negedge clk);
        // Scramble inputs: the latched base/stride/tile must not follow them.
        bus.c_valid    = 1'b0;
        bus.c_addr     = 32'hBAD0_0000;
        bus.row_stride = 32'h0000_0BAD;
        bus.c_data     = make_tile(32'hEE00_0000);
        check("first_req_latency", 32'(bus.wr_valid),   32'd1);
        check("tile_ready_drain",  32'(bus.tile_ready), 32'd0);
        while (!done && cyc < 400) begin
            bus.c_valid = 1'b0;
            if (v.abort_at >= 0 && widx == v.abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_wr_valid",  32'(bus.wr_valid),  32'd0);
                check("abort_tile_done", 32'(bus.tile_done), 32'd0);
                n_valid = vcyc;
                n_acc   = widx;
                return;
            end
            if (bus.tile_done) begin
                done = 1;
                check("done_after_last_word", 32'(widx),           32'd64);
                check("done_wr_valid_low",    32'(bus.wr_valid),   32'd0);
                check("done_tile_ready_high", 32'(bus.tile_ready), 32'd1);
            end else begin
                check("wr_valid_in_drain", 32'(bus.wr_valid), 32'd1);
                if (prev_stall) begin
                    check("stall_addr_stable", bus.wr_addr, p_addr);
                    check("stall_data_stable", bus.wr_data, p_data);
                end
                bus.wr_ready = v.stall ? ((vcyc % 2) == 1) : 1'b1;
                vcyc++;
                if (bus.wr_ready) begin
                    r = widx / 8;
                    c = widx % 8;
                    exp_a = v.base + 32'(r) * v.stride + 32'(c * 4);
                    exp_d = v.tag + 32'(r * 16 + c);
                    check("wr_addr", bus.wr_addr,        exp_a);
                    check("wr_data", bus.wr_data,        exp_d);
                    check("wr_strb", 32'(bus.wr_strb),   32'hF);
                    if (widx == 0)  check("first_addr", bus.wr_addr, v.exp_first_addr);
                    if (widx == 8)  check("row1_addr",  bus.wr_addr, v.exp_mid_addr);
                    if (widx == 63) check("last_addr",  bus.wr_addr, v.exp_last_addr);
                    widx++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    p_addr = bus.wr_addr;
                    p_data = bus.wr_data;
                end
                if (v.inject_at >= 0 && widx == v.inject_at && bus.wr_ready) begin
                    bus.c_valid = 1'b1;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.c_valid = 1'b0;
        if (!done) check("tile_done_timeout", 32'd0, 32'd1);
        n_valid = vcyc;
        n_acc   = widx;
    endtask

    initial begin
        int nv, na;
        bit seen;

        //          base          stride      tag        st inj ab ch first         last          row1          nv   ww    ovf
        vecs[0] = '{32'h0000_1000, 32'h100, 32'h000, 0, -1, -1, 0, 32'h0000_1000, 32'h0000_171C, 32'h0000_1100, 64,  32'd64,  1'b0};
        vecs[1] = '{32'h0000_1000, 32'h100, 32'h000, 1, -1, -1, 0, 32'h0000_1000, 32'h0000_171C, 32'h0000_1100, 128, 32'd128, 1'b0};
        vecs[2] = '{32'h0000_3000, 32'h080, 32'h200, 0, -1, 30, 0, 32'h0000_3000, 32'h0000_0000, 32'h0000_3080, 0,   32'd0,   1'b0};
        vecs[3] = '{32'hFFFF_FFF8, 32'h010, 32'h300, 0, -1, -1, 1, 32'hFFFF_FFF8, 32'h0000_0084, 32'h0000_0008, 64,  32'd64,  1'b0};
        vecs[4] = '{32'h0000_4000, 32'h020, 32'h400, 0, -1, -1, 0, 32'h0000_4000, 32'h0000_40FC, 32'h0000_4020, 64,  32'd128, 1'b0};
        vecs[5] = '{32'h0000_2000, 32'h040, 32'h500, 0, 10, -1, 0, 32'h0000_2000, 32'h0000_21DC, 32'h0000_2040, 64,  32'd192, 1'b1};

        rst_n          = 1'b0;
        bus.c_addr     = '0;
        bus.c_valid    = 1'b0;
        bus.c_data     = '0;
        bus.row_stride = '0;
        bus.wr_ready   = 1'b0;
        bus.err_clr    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_tile(vecs[i], nv, na);
            if (vecs[i].abort_at >= 0) begin
                @(negedge clk);
                check_reset_values();
                rst_n = 1'b1;
                @(negedge clk);
            end else begin
                check("valid_cycles",  32'(nv),             32'(vecs[i].exp_valid_cycles));
                check("words_written", bus.words_written,   vecs[i].exp_ww);
                check("overflow",      32'(bus.overflow),   32'(vecs[i].exp_ovf));
                if (!vecs[i].chain_next) begin
                    @(negedge clk);
                    check("done_single_pulse", 32'(bus.tile_done),  32'd0);
                    check("idle_tile_ready",   32'(bus.tile_ready), 32'd1);
                end
            end
        end

        // err_clr alone clears the sticky flag.
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Violation and err_clr in the same cycle: set wins.
        bus.c_addr     = 32'h0000_6000;
        bus.row_stride = 32'h0000_0100;
        bus.c_data     = make_tile(32'h600);
        bus.c_valid    = 1'b1;
        bus.wr_ready   = 1'b0;
        @(negedge clk);
        bus.c_valid = 1'b1;
        bus.err_clr = 1'b1;
        bus.c_data  = make_tile(32'h700);
        @(negedge clk);
        bus.c_valid = 1'b0;
        bus.err_clr = 1'b0;
        check("ovf_set_beats_clr", 32'(bus.overflow), 32'd1);
        check("held_word0_addr",   bus.wr_addr,       32'h0000_6000);
        check("held_word0_data",   bus.wr_data,       32'h0000_0600);
        bus.wr_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (bus.tile_done) seen = 1;
        end
        check("final_tile_done",     32'(seen),         32'd1);
        check("final_words_written", bus.words_written, 32'd256);
        bus.wr_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
